// File: rtl/snn_slice_pkg.sv
// Shared types and map constants for one SNN core slice.
// Covers the address map, phase codes and scan FSM states.
package snn_slice_pkg;

  localparam int ADDR_W = 9;

  localparam logic [ADDR_W-1:0] SYN_BASE = 9'd0;
  localparam logic [ADDR_W-1:0] SYN_LAST = 9'd255;
  localparam logic [ADDR_W-1:0] PAR_BASE = 9'd256;
  localparam logic [ADDR_W-1:0] PAR_LAST = 9'd383;
  localparam logic [ADDR_W-1:0] SPK_ADDR = 9'd384;

  typedef enum logic [1:0] {
    PH_IDLE = 2'b00,
    PH_SYN  = 2'b01,
    PH_PAR  = 2'b10,
    PH_SPK  = 2'b11
  } phase_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYN,
    S_PAR,
    S_SPK,
    S_DONE
  } state_t;

endpackage

// File: rtl/slice_scan_ctrl.sv
// Timestep scan sequencer and host arbiter for one slice.
// Walks synapse, param and spike regions, else grants host.
module slice_scan_ctrl
  import snn_slice_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic              rdy_i,
  input  logic              host_req_i,
  input  logic [ADDR_W-1:0] host_addr_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              en_o,
  output logic [1:0]        phase_o,
  output logic              host_gnt_o,
  output logic              busy_o,
  output logic              done_o
);

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic              done_q;
  logic              xfer;

  assign xfer = en_o & rdy_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= S_IDLE;
      cnt    <= SYN_BASE;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort_i && state != S_IDLE) begin
        state <= S_IDLE;
        cnt   <= SYN_BASE;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (start_i) begin
              state <= S_SYN;
              cnt   <= SYN_BASE;
            end
          end
          S_SYN: begin
            if (xfer) begin
              if (cnt == SYN_LAST) state <= S_PAR;
              cnt <= cnt + 9'd1;
            end
          end
          S_PAR: begin
            if (xfer) begin
              if (cnt == PAR_LAST) state <= S_SPK;
              cnt <= cnt + 9'd1;
            end
          end
          S_SPK: begin
            if (xfer) begin
              state  <= S_DONE;
              cnt    <= SYN_BASE;
              done_q <= 1'b1;
            end
          end
          S_DONE: state <= S_IDLE;
          default: begin
            state <= S_IDLE;
            cnt   <= SYN_BASE;
          end
        endcase
      end
    end
  end

  // A start cycle belongs to the scan, so the host gets no beat there.
  always_comb begin
    addr_o     = host_addr_i;
    en_o       = host_req_i & ~start_i;
    host_gnt_o = host_req_i & rdy_i & ~start_i;
    phase_o    = PH_IDLE;
    unique case (state)
      S_IDLE: ;
      S_SYN: begin
        addr_o     = cnt;
        en_o       = 1'b1;
        host_gnt_o = 1'b0;
        phase_o    = PH_SYN;
      end
      S_PAR: begin
        addr_o     = cnt;
        en_o       = 1'b1;
        host_gnt_o = 1'b0;
        phase_o    = PH_PAR;
      end
      S_SPK: begin
        addr_o     = SPK_ADDR;
        en_o       = 1'b1;
        host_gnt_o = 1'b0;
        phase_o    = PH_SPK;
      end
      S_DONE: begin
        addr_o     = cnt;
        en_o       = 1'b0;
        host_gnt_o = 1'b0;
      end
      default: begin
        en_o       = 1'b0;
        host_gnt_o = 1'b0;
      end
    endcase
  end

  assign busy_o = (state != S_IDLE);
  assign done_o = done_q;

endmodule

// File: tb/tb_slice_scan_ctrl.sv
// Randomized self-checking bench for slice_scan_ctrl.
// Reference is the ordered beat list of the slice map.
module tb_slice_scan_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       start_i;
  logic       abort_i;
  logic       rdy_i;
  logic       host_req_i;
  logic [8:0] host_addr_i;
  logic [8:0] addr_o;
  logic       en_o;
  logic [1:0] phase_o;
  logic       host_gnt_o;
  logic       busy_o;
  logic       done_o;

  int n_checks = 0;
  int n_fail   = 0;
  int seq[$];

  slice_scan_ctrl dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .abort_i     (abort_i),
    .rdy_i       (rdy_i),
    .host_req_i  (host_req_i),
    .host_addr_i (host_addr_i),
    .addr_o      (addr_o),
    .en_o        (en_o),
    .phase_o     (phase_o),
    .host_gnt_o  (host_gnt_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [1:0] exp_phase(input int a);
    if (a < 256) return 2'b01;
    if (a < 384) return 2'b10;
    return 2'b11;
  endfunction

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_idle_quiet(input string tag);
    n_checks++;
    if (busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL %s busy_o got %b want 0", tag, busy_o);
    end
    n_checks++;
    if (done_o !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done_o got %b want 0", tag, done_o);
    end
    n_checks++;
    if (phase_o !== 2'b00) begin
      n_fail++;
      $display("FAIL %s phase_o got %b want 00", tag, phase_o);
    end
    n_checks++;
    if (en_o !== host_req_i) begin
      n_fail++;
      $display("FAIL %s en_o got %b want %b", tag, en_o, host_req_i);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    start_i = 0; abort_i = 0; rdy_i = 1;
    host_req_i = 0; host_addr_i = 9'd0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_idle_quiet("reset");
    n_checks++;
    if (host_gnt_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset host_gnt_o got %b want 0", host_gnt_o);
    end
    n_checks++;
    if (addr_o !== 9'd0) begin
      n_fail++;
      $display("FAIL reset addr_o got %0d want 0", addr_o);
    end
    next_cycle();
    rst_i = 1'b0;
    next_cycle();
  endtask

  task automatic test_host();
    host_req_i = 1; host_addr_i = 9'd300; rdy_i = 1;
    @(negedge clk_i);
    n_checks++;
    if (addr_o !== 9'd300 || en_o !== 1'b1 || host_gnt_o !== 1'b1) begin
      n_fail++;
      $display("FAIL host300 addr/en/gnt got %0d/%b/%b want 300/1/1",
               addr_o, en_o, host_gnt_o);
    end
    next_cycle();
    for (int i = 0; i < 30; i++) begin
      host_req_i = 1'($urandom);
      rdy_i = 1'($urandom);
      host_addr_i = 9'($urandom_range(0, 511));
      abort_i = 1'($urandom);
      @(negedge clk_i);
      check_idle_quiet("host_rand");
      n_checks++;
      if (addr_o !== host_addr_i) begin
        n_fail++;
        $display("FAIL host_rand addr_o got %0d want %0d", addr_o, host_addr_i);
      end
      n_checks++;
      if (host_gnt_o !== (host_req_i & rdy_i)) begin
        n_fail++;
        $display("FAIL host_rand host_gnt_o got %b want %b",
                 host_gnt_o, host_req_i & rdy_i);
      end
      next_cycle();
    end
    abort_i = 0; host_req_i = 0;
  endtask

  // mode 0: rdy held high, 1: 0,1,0,1 toggle, 2: random with noise
  task automatic run_scan(input string tag, input int mode,
                          input int abort_at, input int rst_at);
    int idx = 0;
    int zeros = 0;
    int cycles = 0;
    logic r;
    start_i = 1; abort_i = 0;
    host_req_i = 1; host_addr_i = 9'd300;
    rdy_i = 1'($urandom);
    @(negedge clk_i);
    n_checks++;
    if (host_gnt_o !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL %s start gnt/busy got %b/%b want 0/0",
               tag, host_gnt_o, busy_o);
    end
    next_cycle();
    start_i = 0;
    while (idx < seq.size() && cycles < 4000) begin
      case (mode)
        0: r = 1'b1;
        1: r = 1'(cycles % 2);
        default: r = 1'($urandom);
      endcase
      if (idx == abort_at) r = 1'b1;
      rdy_i = r;
      abort_i = (idx == abort_at);
      host_req_i = 1'($urandom);
      host_addr_i = 9'($urandom_range(0, 511));
      start_i = (mode == 2) ? 1'($urandom) : 1'b0;
      @(negedge clk_i);
      n_checks++;
      if (addr_o !== 9'(seq[idx])) begin
        n_fail++;
        $display("FAIL %s addr_o got %0d want %0d", tag, addr_o, seq[idx]);
      end
      n_checks++;
      if (en_o !== 1'b1 || busy_o !== 1'b1 || done_o !== 1'b0) begin
        n_fail++;
        $display("FAIL %s en/busy/done at %0d got %b/%b/%b want 1/1/0",
                 tag, seq[idx], en_o, busy_o, done_o);
      end
      n_checks++;
      if (phase_o !== exp_phase(seq[idx])) begin
        n_fail++;
        $display("FAIL %s phase_o at %0d got %b want %b",
                 tag, seq[idx], phase_o, exp_phase(seq[idx]));
      end
      n_checks++;
      if (host_gnt_o !== 1'b0) begin
        n_fail++;
        $display("FAIL %s host_gnt_o in scan got 1 want 0", tag);
      end
      if (idx == rst_at) begin
        #2;
        rst_i = 1'b1;
        host_req_i = 0;
        start_i = 0;
        #1;
        check_idle_quiet({tag, "_async"});
        n_checks++;
        if (addr_o !== host_addr_i || host_gnt_o !== 1'b0) begin
          n_fail++;
          $display("FAIL %s_async addr/gnt got %0d/%b want %0d/0",
                   tag, addr_o, host_gnt_o, host_addr_i);
        end
        next_cycle();
        rst_i = 1'b0;
        next_cycle();
        return;
      end
      if (idx == abort_at) begin
        next_cycle();
        abort_i = 0; start_i = 0; host_req_i = 0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk_i);
          check_idle_quiet({tag, "_abort"});
          next_cycle();
        end
        return;
      end
      cycles++;
      if (r) idx++;
      else zeros++;
      next_cycle();
    end
    start_i = 0; host_req_i = 0; abort_i = 0;
    n_checks++;
    if (cycles >= 4000) begin
      n_fail++;
      $display("FAIL %s timeout idx got %0d want %0d", tag, idx, seq.size());
    end
    n_checks++;
    if (cycles !== seq.size() + zeros) begin
      n_fail++;
      $display("FAIL %s beat cycles got %0d want %0d",
               tag, cycles, seq.size() + zeros);
    end
    @(negedge clk_i);
    n_checks++;
    if (done_o !== 1'b1 || en_o !== 1'b0 || busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL %s done cycle done/en/busy got %b/%b/%b want 1/0/1",
               tag, done_o, en_o, busy_o);
    end
    n_checks++;
    if (host_gnt_o !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done cycle host_gnt_o got 1 want 0", tag);
    end
    next_cycle();
    @(negedge clk_i);
    check_idle_quiet({tag, "_end"});
    next_cycle();
  endtask

  task automatic test_full_scan();
    run_scan("full", 0, -1, -1);
  endtask

  task automatic test_toggle_scan();
    run_scan("toggle", 1, -1, -1);
  endtask

  task automatic test_random_scan();
    run_scan("random", 2, -1, -1);
  endtask

  task automatic test_start_with_host();
    host_req_i = 1; host_addr_i = 9'd300; rdy_i = 1; start_i = 1;
    @(negedge clk_i);
    n_checks++;
    if (host_gnt_o !== 1'b0) begin
      n_fail++;
      $display("FAIL start_host host_gnt_o got 1 want 0");
    end
    next_cycle();
    start_i = 0; rdy_i = 0;
    @(negedge clk_i);
    n_checks++;
    if (addr_o !== 9'd0 || phase_o !== 2'b01 || host_gnt_o !== 1'b0) begin
      n_fail++;
      $display("FAIL start_host next addr/phase/gnt got %0d/%b/%b want 0/01/0",
               addr_o, phase_o, host_gnt_o);
    end
    next_cycle();
    abort_i = 1;
    next_cycle();
    abort_i = 0; host_req_i = 0;
    @(negedge clk_i);
    check_idle_quiet("start_host_abort");
    next_cycle();
  endtask

  task automatic test_abort();
    run_scan("abort150", 2, 150, -1);
    run_scan("restart", 0, -1, -1);
    run_scan("abort_spk", 0, 384, -1);
    run_scan("restart2", 2, -1, -1);
  endtask

  task automatic test_async_reset();
    run_scan("rst200", 2, -1, 200);
    run_scan("post_rst", 0, -1, -1);
  endtask

  initial begin
    for (int i = 0; i <= 384; i++) seq.push_back(i);
    test_reset();
    test_host();
    test_full_scan();
    test_toggle_scan();
    test_random_scan();
    test_start_with_host();
    test_abort();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
